// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// wait-counter width and the alignment predicate.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmemStateT;

   // Size 2'b11 is handled exactly like a word access.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addrLo[0];
         default: mis = (addrLo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Memory-stage request/response bundle between the pipeline (master) and
// the data-memory responder (slave).
interface dmem_if;

   // Handshake: the master raises req_i with all request fields and holds
   // them stable until it sees ready_o; ready_o is a single-cycle completion
   // pulse, and rdata_o/err_o are meaningful only while ready_o is high.
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        signed_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        err_o;

   modport master (
      output req_i, we_i, size_i, signed_i, addr_i, wdata_i,
      input  ready_o, rdata_o, busy_o, err_o
   );

   modport slave (
      input  req_i, we_i, size_i, signed_i, addr_i, wdata_i,
      output ready_o, rdata_o, busy_o, err_o
   );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Little-endian lane logic: merges store data into a memory word and
// extracts/extends a byte, halfword or word for loads.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [31:0] memWord,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        signedLd,
   input  logic [1:0]  addrLo,
   output logic [31:0] newWord,
   output logic [31:0] rdata
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   always_comb begin
      newWord = memWord;
      case (size)
         SZ_BYTE: newWord[{addrLo, 3'b000} +: 8]   = wdata[7:0];
         SZ_HALF: newWord[{addrLo[1], 4'b0000} +: 16] = wdata[15:0];
         default: newWord = wdata;
      endcase
   end

   // Halfword lanes only look at addr[1]; word accesses ignore both low bits.
   always_comb begin
      ldByte = memWord[{addrLo, 3'b000} +: 8];
      ldHalf = memWord[{addrLo[1], 4'b0000} +: 16];
      rdata  = memWord;
      case (size)
         SZ_BYTE: rdata = {{24{signedLd & ldByte[7]}}, ldByte};
         SZ_HALF: rdata = {{16{signedLd & ldHalf[15]}}, ldHalf};
         default: rdata = memWord;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage. Define
// DMEM_ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
)(
   input  logic      clk,
   input  logic      rst,
   dmem_if.slave     bus,
   output dmemStateT stateDbg
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   dmemStateT        state;
   dmemStateT        stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;

   logic             curWe;
   logic [1:0]       curSize;
   logic             curSigned;
   logic [IDX_W+1:0] curAddr;
   logic [31:0]      curWdata;
   logic [31:0]      rdataHold;

   logic [IDX_W-1:0] wordIdx;
   logic [31:0]      memWord;
   logic [31:0]      newWord;
   logic [31:0]      loadData;
   logic [31:0]      respData;
   logic             inResp;
   logic             alignErr;
   logic             accept;
   logic             unusedAddrHi;

   assign unusedAddrHi = ^bus.addr_i[31:IDX_W+2];

   assign wordIdx = curAddr[IDX_W+1:2];
   assign memWord = mem[wordIdx];
   assign inResp  = (state == RESP);
   assign accept  = (state == IDLE) && bus.req_i;

`ifdef DMEM_ALIGN_CHECK_EN
   assign alignErr = isMisaligned(curSize, curAddr[1:0]);
`else
   assign alignErr = 1'b0;
`endif

   dmem_lane_fmt u_laneFmt (
      .memWord  (memWord),
      .wdata    (curWdata),
      .size     (curSize),
      .signedLd (curSigned),
      .addrLo   (curAddr[1:0]),
      .newWord  (newWord),
      .rdata    (loadData)
   );

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         IDLE: begin
            if (bus.req_i) begin
               cntNext   = CNT_W'(WAIT_CYCLES);
               stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cntNext = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) stateNext = RESP;
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         curWe     <= 1'b0;
         curSize   <= SZ_BYTE;
         curSigned <= 1'b0;
         curAddr   <= '0;
         curWdata  <= '0;
         rdataHold <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (accept) begin
            curWe     <= bus.we_i;
            curSize   <= bus.size_i;
            curSigned <= bus.signed_i;
            curAddr   <= bus.addr_i[IDX_W+1:0];
            curWdata  <= bus.wdata_i;
         end
         if (inResp) rdataHold <= respData;
      end
   end

   // Reset forces IDLE asynchronously, so an interrupted store never reaches RESP.
   always_ff @(posedge clk) begin
      if (inResp && curWe && !alignErr) mem[wordIdx] <= newWord;
   end

   // Stores leave the previous load result on rdata_o.
   always_comb begin
      respData = loadData;
      if (alignErr)   respData = '0;
      else if (curWe) respData = rdataHold;
   end

   assign bus.ready_o = inResp;
   assign bus.err_o   = inResp & alignErr;
   assign bus.rdata_o = inResp ? respData : rdataHold;
   assign bus.busy_o  = bus.req_i & ~inResp;
   assign stateDbg    = state;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline's memory-stage port: it accepts one load or store request at a time from the M stage (address from the ALU result, store data from the forwarded rt value), completes it after a configurable number of wait cycles and returns load data to the writeback path. While a request is outstanding it raises a stall request for the hazard unit, so the core can tolerate multi-cycle memory.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; word index is addr_i[log2(DEPTH_WORDS)+1:2], upper address bits ignored (wrap).
- WAIT_CYCLES, 2: wait states between acceptance and response, legal 0..15.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  request valid from M stage; held with all request fields stable until ready_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- signed_i  in  1  loads only: 1 sign-extends byte/half, 0 zero-extends.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready_o  out  1  one-cycle pulse: request complete.
- rdata_o  out  32  load result, valid when ready_o; holds last value otherwise.
- busy_o  out  1  stall request = req_i & ~ready_o.
- err_o  out  1  misaligned access flag, valid with ready_o.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req_i, capture we/size/signed/addr/wdata, load counter with WAIT_CYCLES; go to WAIT, or directly to RESP if WAIT_CYCLES=0.
- WAIT: decrement counter each cycle; at counter==1 go to RESP.
- RESP: ready_o=1 for exactly this cycle; store committed on the clock edge ending RESP; load data presented on rdata_o during RESP; next state IDLE unconditionally. A new request is accepted only from IDLE.
- Little-endian lanes: byte addr[1:0]=0 is bits [7:0]; halfword addr[1]=0 is [15:0].
- Stores write only the addressed lane(s); other bytes of the word unchanged.
- Loads extract lane and extend per signed_i; word loads ignore signed_i.
- Memory array is not reset; contents undefined until written.

## Timing
- Request accepted at edge T (in IDLE) -> ready_o high in cycle T+1+WAIT_CYCLES; store visible to a load accepted afterwards.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- busy_o is combinational; high in the acceptance cycle and all WAIT cycles, low in RESP.
- Reset values: state IDLE, ready_o 0, rdata_o 0, err_o 0, busy_o = 0 while req_i low.
- Reset asserted mid-request: return to IDLE immediately, pending store discarded, no ready_o pulse.
- req_i dropped before ready_o: protocol violation; behaviour undefined (bench asserts it never happens).

## Configuration
- DMEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 completes normally in time, but err_o=1 with ready_o, store suppressed, rdata_o=0.
- Undefined: err_o tied 0; low address bits ignored for the access size (half uses addr[1] only, word uses neither).

## Structure
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, WAIT counter width constant (4).
- One combinational sub-module dmem_lane_fmt: store merge (old word, wdata, size, addr[1:0] -> new word) and load extract (word, size, signed, addr[1:0] -> rdata).

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10, WAIT_CYCLES=2 -> ready_o at T+3 each time, rdata_o=0xDEADBEEF, busy_o high exactly 3 cycles per request.
- Byte store 0x80 to 0x13 over 0x00000000, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80000000.
- Half store 0x1234 at 0x22 over 0xAAAAAAAA, then lw 0x20 -> 0x1234AAAA; lh 0x22 -> 0x00001234.
- WAIT_CYCLES=0: back-to-back requests -> ready_o every second cycle, latency 1.
- With DMEM_ALIGN_CHECK_EN, sw to 0x21 -> err_o=1 with ready_o, lw 0x20 unchanged; without macro, same sw writes word 0x20, err_o=0.
- Assert rst during WAIT of a store to 0x30 -> no ready_o, outputs 0, later lw 0x30 returns prior contents.
